// File: rtl/conta_pkg.sv
// Shared types and constants for the three-decade BCD counter and the seven-segment stage.
package conta_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;
  localparam int   NDIG    = 3;

  // Next value of one decade for a single step. An illegal code (10..15)
  // falls back to 0 so a corrupted cell heals on its next step.
  function automatic bcd_t bcd_next(input bcd_t q, input logic up_dn);
    bcd_t r;
    if (q > BCD_MAX) begin
      r = '0;
    end else if (up_dn) begin
      r = (q == BCD_MAX) ? bcd_t'(0) : bcd_t'(q + 4'd1);
    end else begin
      r = (q == bcd_t'(0)) ? BCD_MAX : bcd_t'(q - 4'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade cell of the up/down counter chain.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clr       - synchronous clear to 0 (beats a coincident step)
//   en        - count step strobe shared by all decades
//   up_dn     - 1 = count up, 0 = count down
//   cin       - carry/borrow from the lower decade (tie 1 for the units cell)
//   q         - registered BCD digit
//   cout      - combinational carry/borrow into the next decade
module bcd_digit
  import conta_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic up_dn,
  input  logic cin,
  output bcd_t q,
  output logic cout
);

  bcd_t q_q;
  bcd_t q_d;

  // Digit advances only when the step reaches this decade through the carry chain.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en && cin) begin
      q_d = bcd_next(q_q, up_dn);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q    = q_q;
  assign cout = en & cin & (up_dn ? (q_q == BCD_MAX) : (q_q == bcd_t'(0)));

endmodule

// File: rtl/bcd_counter_3d.sv
// Three-decade BCD up/down counter (000..999) with run/stop pushbutton and prescaler.
// Ports:
//   clk      - system clock
//   rst      - synchronous reset, active-high, overrides everything
//   run_btn  - asynchronous run/stop button; each rising edge toggles running
//   up_dn    - count direction (1 = up), sampled on the step edge
//   clr      - synchronous clear of digits, prescaler and pulses
//   d1/d2/d3 - units / tens / hundreds BCD digits
//   running  - 1 while counting
//   tick_o   - 1-cycle pulse aligned with newly stepped digits
//   wrap_o   - 1-cycle pulse with tick_o when the step wrapped 999<->000
module bcd_counter_3d
  import conta_pkg::*;
#(
  parameter int unsigned CLK_DIV = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_btn,
  input  logic       up_dn,
  input  logic       clr,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic       running,
  output logic       tick_o,
  output logic       wrap_o
);

  localparam int unsigned PRE_W = $clog2(CLK_DIV + 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             prev_q, prev_d;
  logic             running_q, running_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;

  logic             btn_rise_c;
  logic             step_c;
  logic             wrap_c;
  logic [NDIG:0]    carry;
  bcd_t             dig [NDIG];

  // Next-state logic for synchroniser, run toggle, prescaler and output pulses.
  always_comb begin
    s1_d      = run_btn;
    s2_d      = s1_q;
    prev_d    = s2_q;
    btn_rise_c = s2_q & ~prev_q;
    running_d = running_q ^ btn_rise_c;

    // Step decision uses the registered running, so a stop edge landing on
    // the terminal count still lets that final step through.
    step_c = running_q & (pre_q == PRE_LAST);

    pre_d = pre_q;
    if (clr) begin
      pre_d = '0;
    end else if (running_q) begin
      pre_d = step_c ? '0 : PRE_W'(pre_q + PRE_W'(1));
    end

    tick_d = step_c & ~clr;
    wrap_d = wrap_c & ~clr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      prev_q    <= 1'b0;
      running_q <= 1'b0;
      pre_q     <= '0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      prev_q    <= prev_d;
      running_q <= running_d;
      pre_q     <= pre_d;
      tick_q    <= tick_d;
      wrap_q    <= wrap_d;
    end
  end

  // Decade chain: units always sees the step, higher decades only on carry/borrow.
  assign carry[0] = 1'b1;

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    bcd_digit u_digit (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .en    (step_c),
      .up_dn (up_dn),
      .cin   (carry[g]),
      .q     (dig[g]),
      .cout  (carry[g+1])
    );
  end

  assign wrap_c = carry[NDIG];

  assign d1      = dig[0];
  assign d2      = dig[1];
  assign d3      = dig[2];
  assign running = running_q;
  assign tick_o  = tick_q;
  assign wrap_o  = wrap_q;

  // Digits stay in BCD range and a wrap pulse never appears without its tick.
  a_digits_bcd : assert property (@(posedge clk) disable iff (rst)
    (d1 <= BCD_MAX) && (d2 <= BCD_MAX) && (d3 <= BCD_MAX));
  a_wrap_has_tick : assert property (@(posedge clk) disable iff (rst)
    wrap_o |-> tick_o);

endmodule

// File: tb/tb_bcd_counter_3d.sv
// Bench for bcd_counter_3d with CLK_DIV=4: behavioural reference model feeds a
// scoreboard queue every cycle; scenario tasks add targeted checks.
module tb_bcd_counter_3d;

  localparam int unsigned CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       run_btn;
  logic       up_dn;
  logic       clr;
  logic [3:0] d1, d2, d3;
  logic       running, tick_o, wrap_o;

  always #5 clk = ~clk;

  bcd_counter_3d #(.CLK_DIV(CLK_DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .run_btn (run_btn),
    .up_dn   (up_dn),
    .clr     (clr),
    .d1      (d1),
    .d2      (d2),
    .d3      (d3),
    .running (running),
    .tick_o  (tick_o),
    .wrap_o  (wrap_o)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [14:0] exp_q[$];

  // Reference model: decimal count plus run/prescaler state.
  int m_cnt  = 0;
  int m_pre  = 0;
  bit m_s1   = 0;
  bit m_s2   = 0;
  bit m_prev = 0;
  bit m_run  = 0;
  bit m_tick = 0;
  bit m_wrap = 0;

  function automatic logic [14:0] pack(input int cnt, input bit r, input bit t, input bit w);
    return {4'(cnt / 100), 4'((cnt / 10) % 10), 4'(cnt % 10), r, t, w};
  endfunction

  function automatic logic [14:0] obs();
    return {d3, d2, d1, running, tick_o, wrap_o};
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit rise, step;
    if (rst) begin
      m_cnt = 0; m_pre = 0; m_s1 = 0; m_s2 = 0; m_prev = 0;
      m_run = 0; m_tick = 0; m_wrap = 0;
    end else begin
      rise = m_s2 & ~m_prev;
      step = m_run && (m_pre == int'(CLK_DIV) - 1);
      if (clr) begin
        m_cnt = 0; m_pre = 0; m_tick = 0; m_wrap = 0;
      end else begin
        if (m_run) m_pre = step ? 0 : m_pre + 1;
        m_tick = step;
        m_wrap = 0;
        if (step) begin
          if (up_dn) begin
            m_wrap = (m_cnt == 999);
            m_cnt  = (m_cnt + 1) % 1000;
          end else begin
            m_wrap = (m_cnt == 0);
            m_cnt  = (m_cnt + 999) % 1000;
          end
        end
      end
      m_prev = m_s2;
      m_s2   = m_s1;
      m_s1   = run_btn;
      m_run  = m_run ^ rise;
    end
  endtask

  // One clock: push the expectation, let the edge happen, return 1 ns later.
  task automatic cyc();
    model_step();
    exp_q.push_back(pack(m_cnt, m_run, m_tick, m_wrap));
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare each cycle's outputs on the falling edge.
  logic [14:0] sb_exp;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      sb_exp = exp_q.pop_front();
      n_chk++;
      if (obs() !== sb_exp)
        $display("FAIL scoreboard t=%0t: got %h want %h", $time, obs(), sb_exp);
      else
        n_pass++;
    end
  end

  // Run until both model and DUT show a step (to a given count, or any if target<0).
  task automatic wait_step(input int target, input int lim, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      cyc();
      if (tick_o === 1'b1 && m_tick && (target < 0 || m_cnt == target)) begin
        ok = 1'b1;
        break;
      end
    end
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: no step to %0d within %0d cycles", tag, target, lim);
  endtask

  task automatic wait_pre_last();
    for (int i = 0; i < 8; i++) begin
      if (m_pre == int'(CLK_DIV) - 1) break;
      cyc();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; run_btn = 1'b0; up_dn = 1'b1; clr = 1'b0;
    cyc();
    cyc();
    n_chk++;
    if (obs() !== 15'h0000) $display("FAIL reset_state: got %h want %h", obs(), 15'h0000);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_run_start();
    int rise_at, ticks;
    rise_at = 0; ticks = 0;
    run_btn = 1'b1;
    for (int i = 1; i <= 43; i++) begin
      if (i == 6) run_btn = 1'b0;
      cyc();
      if (running === 1'b1 && rise_at == 0) rise_at = i;
      if (tick_o === 1'b1) ticks++;
    end
    n_chk++;
    if (rise_at != 3) $display("FAIL run_latency: got %0d want %0d", rise_at, 3);
    else n_pass++;
    n_chk++;
    if (ticks != 10) $display("FAIL tick_count: got %0d want %0d", ticks, 10);
    else n_pass++;
    n_chk++;
    if ({d3, d2, d1, running, tick_o} !== {12'h010, 1'b1, 1'b1})
      $display("FAIL count_010: got %h want %h", {d3, d2, d1, running, tick_o}, {12'h010, 2'b11});
    else n_pass++;
  endtask

  task automatic test_wrap_up();
    up_dn = 1'b1;
    wait_step(998, 5000, "to_998");
    wait_step(999, 8, "to_999");
    wait_step(-1, 8, "wrap_up");
    n_chk++;
    if ({d3, d2, d1, tick_o, wrap_o} !== {12'h000, 2'b11})
      $display("FAIL wrap_up: got %h want %h", {d3, d2, d1, tick_o, wrap_o}, {12'h000, 2'b11});
    else n_pass++;
    cyc();
    n_chk++;
    if ({tick_o, wrap_o} !== 2'b00) $display("FAIL wrap_pulse_len: got %b want %b", {tick_o, wrap_o}, 2'b00);
    else n_pass++;
    wait_step(-1, 8, "after_wrap");
    n_chk++;
    if ({d3, d2, d1, tick_o, wrap_o} !== {12'h001, 2'b10})
      $display("FAIL after_wrap: got %h want %h", {d3, d2, d1, tick_o, wrap_o}, {12'h001, 2'b10});
    else n_pass++;
  endtask

  task automatic test_down();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    up_dn = 1'b0;
    n_chk++;
    if ({d3, d2, d1, running, tick_o} !== {12'h000, 2'b10})
      $display("FAIL clr_to_000: got %h want %h", {d3, d2, d1, running, tick_o}, {12'h000, 2'b10});
    else n_pass++;
    wait_step(-1, 8, "wrap_down");
    n_chk++;
    if ({d3, d2, d1, tick_o, wrap_o} !== {12'h999, 2'b11})
      $display("FAIL wrap_down: got %h want %h", {d3, d2, d1, tick_o, wrap_o}, {12'h999, 2'b11});
    else n_pass++;
    wait_step(-1, 8, "to_998_dn");
    n_chk++;
    if ({d3, d2, d1, wrap_o} !== {12'h998, 1'b0})
      $display("FAIL down_998: got %h want %h", {d3, d2, d1, wrap_o}, {12'h998, 1'b0});
    else n_pass++;
    wait_step(990, 100, "to_990");
    wait_step(-1, 8, "tens_borrow");
    n_chk++;
    if ({d3, d2, d1} !== 12'h989) $display("FAIL tens_borrow: got %h want %h", {d3, d2, d1}, 12'h989);
    else n_pass++;
    wait_step(900, 500, "to_900");
    wait_step(-1, 8, "hund_borrow");
    n_chk++;
    if ({d3, d2, d1} !== 12'h899) $display("FAIL hundreds_borrow: got %h want %h", {d3, d2, d1}, 12'h899);
    else n_pass++;
  endtask

  task automatic test_stop_resume();
    logic [11:0] snap;
    int ticks, changes, r_at, t_at;
    wait_pre_last();
    run_btn = 1'b1;
    cyc(); cyc(); cyc();
    run_btn = 1'b0;
    n_chk++;
    if (running !== 1'b0) $display("FAIL stop: got %b want %b", running, 1'b0);
    else n_pass++;
    snap = {d3, d2, d1};
    ticks = 0; changes = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (tick_o === 1'b1) ticks++;
      if ({d3, d2, d1} !== snap) changes++;
    end
    n_chk++;
    if (ticks != 0 || changes != 0)
      $display("FAIL idle_frozen: got ticks=%0d changes=%0d want 0 0", ticks, changes);
    else n_pass++;
    run_btn = 1'b1;
    r_at = -1; t_at = -1;
    for (int i = 0; i < 20; i++) begin
      if (i == 2) run_btn = 1'b0;
      cyc();
      if (running === 1'b1 && r_at < 0) r_at = i;
      if (tick_o === 1'b1 && t_at < 0) begin t_at = i; break; end
    end
    // Phase was frozen at pre=2, so two more cycles reach the terminal count.
    n_chk++;
    if (r_at < 0 || t_at - r_at != 2)
      $display("FAIL resume_phase: got %0d want %0d", t_at - r_at, 2);
    else n_pass++;
  endtask

  task automatic test_clr_step();
    int n;
    up_dn = 1'b1;
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    wait_step(456, 2100, "to_456");
    wait_pre_last();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    n_chk++;
    if ({d3, d2, d1, running, tick_o, wrap_o} !== {12'h000, 3'b100})
      $display("FAIL clr_beats_step: got %h want %h", obs(), {12'h000, 3'b100});
    else n_pass++;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      n++;
      if (tick_o === 1'b1) break;
    end
    n_chk++;
    if (n != 4 || {d3, d2, d1} !== 12'h001)
      $display("FAIL clr_restart: got %0d cycles %h want 4 cycles 001", n, {d3, d2, d1});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    wait_step(123, 700, "to_123");
    rst = 1'b1;
    run_btn = 1'b1;
    clr = 1'b1;
    cyc();
    rst = 1'b0; run_btn = 1'b0; clr = 1'b0;
    n_chk++;
    if (obs() !== 15'h0000) $display("FAIL reset_mid: got %h want %h", obs(), 15'h0000);
    else n_pass++;
    // Sub-cycle glitch between edges: never sampled, must not toggle.
    #2 run_btn = 1'b1;
    #3 run_btn = 1'b0;
    repeat (6) cyc();
    n_chk++;
    if ({running, d3, d2, d1} !== 13'h0000)
      $display("FAIL glitch_ignored: got %h want %h", {running, d3, d2, d1}, 13'h0000);
    else n_pass++;
    // One-cycle pulse spanning an edge: toggles exactly once.
    run_btn = 1'b1;
    cyc();
    run_btn = 1'b0;
    repeat (8) cyc();
    n_chk++;
    if (running !== 1'b1) $display("FAIL pulse_once: got %b want %b", running, 1'b1);
    else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_run_start();
    test_wrap_up();
    test_down();
    test_stop_resume();
    test_clr_step();
    test_reset_mid();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
